// File: rtl/lbist_pkg.sv
// lbist_pkg -- shared definitions for the logic-BIST controller.
//   state_t        : controller FSM states
//   LFSR_W_DEF     : default PRPG/MISR width
//   *_POLY_DEF     : default Galois feedback masks
//   PRPG_SEED_DEF  : default PRPG start value
package lbist_pkg;

  localparam int          LFSR_W_DEF    = 16;
  localparam logic [15:0] PRPG_POLY_DEF = 16'hB400;
  localparam logic [15:0] PRPG_SEED_DEF = 16'hACE1;
  localparam logic [15:0] MISR_POLY_DEF = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    UNLOAD,
    FIN
  } state_t;

endpackage

// File: rtl/lbist_ctrl_if.sv
// lbist_ctrl_if -- control and scan-chain signals of the BIST controller.
//   START/NUM_PAT/ABORT : run control from the host
//   SO                  : tail of the scan chain
//   SSEL/SDIN           : scan-select and chain head data
//   SIG/BUSY/DONE       : run status and final signature
// master = host/chain side, slave = controller side.
interface lbist_ctrl_if
  import lbist_pkg::*;
#(
  parameter int LFSR_W = LFSR_W_DEF
);

  logic              START;
  logic [15:0]       NUM_PAT;
  logic              ABORT;
  logic              SO;
  logic              SSEL;
  logic              SDIN;
  logic [LFSR_W-1:0] SIG;
  logic              BUSY;
  logic              DONE;

  modport master (
    output START, NUM_PAT, ABORT, SO,
    input  SSEL, SDIN, SIG, BUSY, DONE
  );

  modport slave (
    input  START, NUM_PAT, ABORT, SO,
    output SSEL, SDIN, SIG, BUSY, DONE
  );

endinterface

// File: rtl/lbist_lfsr.sv
// lbist_lfsr -- Galois LFSR step register, used both as PRPG and as MISR.
//   clk  : clock
//   srst : synchronous active-high reset, loads SEED
//   init : loads SEED (start of a run)
//   en   : advance one step
//   sin  : serial input XORed into bit 0 (tie 0 for a plain generator)
//   q    : current register value
module lbist_lfsr #(
  parameter int           W    = 16,
  parameter logic [W-1:0] POLY = '0,
  parameter logic [W-1:0] SEED = '0
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         init,
  input  logic         en,
  input  logic         sin,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;
  logic [W-1:0] q_next;

  always_comb begin
    q_next = {q_reg[W-2:0], 1'b0} ^ (q_reg[W-1] ? POLY : '0) ^ {{(W-1){1'b0}}, sin};
  end

  always_ff @(posedge clk) begin
    if (srst || init) begin
      q_reg <= SEED;
    end else if (en) begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/lbist_ctrl.sv
// lbist_ctrl -- logic-BIST controller for one scan chain.
// Loads pseudo-random patterns from a PRPG into the chain, pulses one
// functional capture cycle per pattern, and compacts the shifted-out
// responses into a MISR whose final value is published on SIG.
//   CLK : clock
//   RST : synchronous active-high reset
//   bus : lbist_ctrl_if.slave (START, NUM_PAT, ABORT, SO in;
//         SSEL, SDIN, SIG, BUSY, DONE out)
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int                CHAIN_LEN = 534,
  parameter int                LFSR_W    = LFSR_W_DEF,
  parameter logic [LFSR_W-1:0] PRPG_POLY = LFSR_W'(PRPG_POLY_DEF),
  parameter logic [LFSR_W-1:0] PRPG_SEED = LFSR_W'(PRPG_SEED_DEF),
  parameter logic [LFSR_W-1:0] MISR_POLY = LFSR_W'(MISR_POLY_DEF)
) (
  input logic        CLK,
  input logic        RST,
  lbist_ctrl_if.slave bus
);

  localparam int            CW       = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CHAIN_LEN - 1);

  state_t            state_reg;
  logic [CW-1:0]     bit_cnt_reg;
  logic [15:0]       pat_cnt_reg;
  logic [15:0]       num_pat_reg;
  logic [15:0]       pat_inc;
  logic              first_reg;
  logic [LFSR_W-1:0] sig_reg;
  logic [LFSR_W-1:0] prpg;
  logic [LFSR_W-1:0] misr;
  logic              start_ok;
  logic              prpg_en;
  logic              misr_en;
  logic              prpg_unused;

  assign start_ok = (state_reg == IDLE) && bus.START;
  assign pat_inc  = pat_cnt_reg + 16'd1;
  assign prpg_en  = (state_reg == LOAD);
  // The first load shifts out undefined chain contents, so it is not compacted.
  assign misr_en  = (state_reg == UNLOAD) || ((state_reg == LOAD) && !first_reg);

  // Only the PRPG MSB leaves the block; the rest just feeds back.
  assign prpg_unused = ^prpg[LFSR_W-2:0];

  lbist_lfsr #(
    .W   (LFSR_W),
    .POLY(PRPG_POLY),
    .SEED(PRPG_SEED)
  ) u_prpg (
    .clk (CLK),
    .srst(RST),
    .init(start_ok),
    .en  (prpg_en),
    .sin (1'b0),
    .q   (prpg)
  );

  lbist_lfsr #(
    .W   (LFSR_W),
    .POLY(MISR_POLY),
    .SEED('0)
  ) u_misr (
    .clk (CLK),
    .srst(RST),
    .init(start_ok),
    .en  (misr_en),
    .sin (bus.SO),
    .q   (misr)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      pat_cnt_reg <= '0;
      num_pat_reg <= '0;
      first_reg   <= 1'b0;
      sig_reg     <= '0;
    end else if ((state_reg != IDLE) && bus.ABORT) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      pat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.START) begin
            num_pat_reg <= bus.NUM_PAT;
            bit_cnt_reg <= '0;
            pat_cnt_reg <= '0;
            first_reg   <= 1'b1;
            state_reg   <= (bus.NUM_PAT == 16'd0) ? FIN : LOAD;
          end
        end
        LOAD: begin
          if (bit_cnt_reg == BIT_LAST) begin
            bit_cnt_reg <= '0;
            state_reg   <= CAPTURE;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        CAPTURE: begin
          pat_cnt_reg <= pat_inc;
          if (pat_inc == num_pat_reg) begin
            state_reg <= UNLOAD;
          end else begin
            first_reg <= 1'b0;
            state_reg <= LOAD;
          end
        end
        UNLOAD: begin
          if (bit_cnt_reg == BIT_LAST) begin
            bit_cnt_reg <= '0;
            state_reg   <= FIN;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        FIN: begin
          sig_reg   <= misr;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // All outputs decode from registered state; SIG shows the MISR during FIN
  // and the latched copy afterwards.
  assign bus.SSEL = (state_reg == LOAD) || (state_reg == UNLOAD);
  assign bus.SDIN = (state_reg == LOAD) && prpg[LFSR_W-1];
  assign bus.BUSY = (state_reg == LOAD) || (state_reg == CAPTURE) || (state_reg == UNLOAD);
  assign bus.DONE = (state_reg == FIN);
  assign bus.SIG  = (state_reg == FIN) ? misr : sig_reg;

endmodule

// File: tb/tb_lbist_ctrl.sv
// tb_lbist_ctrl -- self-checking bench for lbist_ctrl with an 8-cell chain.
// The chain model: shift when SSEL=1, otherwise each cell captures the
// inverted Q of the previous cell (cell 0 takes the inverted tail).
module tb_lbist_ctrl;

  localparam int L = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lbist_ctrl_if #(.LFSR_W(16)) bus ();

  lbist_ctrl #(.CHAIN_LEN(L)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  logic [L-1:0] chain = '0;
  always @(posedge clk) begin
    if (bus.SSEL) chain <= {chain[L-2:0], bus.SDIN};
    else          chain <= ~{chain[L-2:0], chain[L-1]};
  end
  assign bus.SO = chain[L-1];

  typedef struct {
    logic [15:0] sig;
    int          busy;
    int          caps;
    int          ssels;
  } exp_t;

  exp_t exp_q[$];
  logic exp_sdin_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt = 0;
  int cap_cnt = 0;
  int ssel_cnt = 0;
  int shift_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] x, input logic [15:0] poly,
                                       input logic din);
    return {x[14:0], 1'b0} ^ (x[15] ? poly : 16'h0000) ^ {15'h0000, din};
  endfunction

  // Golden model of a complete run: signature after n patterns.
  function automatic logic [15:0] model_sig(input int n);
    logic [15:0]  prpg = 16'hACE1;
    logic [15:0]  misr = 16'h0000;
    logic [L-1:0] ch = '0;
    for (int p = 0; p < n; p++) begin
      for (int b = 0; b < L; b++) begin
        if (p != 0) misr = step(misr, 16'hB400, ch[L-1]);
        ch   = {ch[L-2:0], prpg[15]};
        prpg = step(prpg, 16'hB400, 1'b0);
      end
      ch = ~{ch[L-2:0], ch[L-1]};
    end
    if (n > 0) begin
      for (int b = 0; b < L; b++) begin
        misr = step(misr, 16'hB400, ch[L-1]);
        ch   = {ch[L-2:0], 1'b0};
      end
    end
    return misr;
  endfunction

  // Monitor: accumulates per-run activity and scores it on DONE.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = busy_cnt;
    end else if (bus.START && !bus.BUSY && !bus.DONE) begin
      busy_cnt  = 0;
      cap_cnt   = 0;
      ssel_cnt  = 0;
      shift_idx = 0;
    end else begin
      if (bus.BUSY) busy_cnt++;
      if (bus.BUSY && !bus.SSEL) cap_cnt++;
      if (bus.SSEL) begin
        ssel_cnt++;
        if (shift_idx < L && exp_sdin_q.size() > 0) begin
          check($sformatf("sdin[%0d]", shift_idx), {31'b0, bus.SDIN},
                {31'b0, exp_sdin_q.pop_front()});
        end
        shift_idx++;
      end
      if (bus.DONE) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("run: sig=%h busy=%0d caps=%0d ssels=%0d", bus.SIG, busy_cnt, cap_cnt, ssel_cnt);
          check("sig", {16'b0, bus.SIG}, {16'b0, e.sig});
          check("busy_cycles", busy_cnt, e.busy);
          check("capture_cycles", cap_cnt, e.caps);
          check("ssel_cycles", ssel_cnt, e.ssels);
        end
      end
    end
  end

  task automatic start_run(input int n);
    logic [15:0] p;
    p = 16'hACE1;
    if (n > 0) begin
      for (int i = 0; i < L; i++) begin
        exp_sdin_q.push_back(p[15]);
        p = step(p, 16'hB400, 1'b0);
      end
    end
    @(posedge clk);
    #1;
    bus.START   = 1'b1;
    bus.NUM_PAT = 16'(n);
    @(posedge clk);
    #1;
    bus.START = 1'b0;
  endtask

  // Full run; optionally pulses START again (ignored) on cycle pulse_at.
  task automatic run(input int n, input int pulse_at);
    int lat;
    int k;
    bit got;
    exp_t e;
    lat     = (n == 0) ? 1 : n * (L + 1) + L + 1;
    e.sig   = model_sig(n);
    e.busy  = (n == 0) ? 0 : n * (L + 1) + L;
    e.caps  = n;
    e.ssels = (n == 0) ? 0 : (n + 1) * L;
    exp_q.push_back(e);
    start_run(n);
    k   = 0;
    got = 1'b0;
    while (k < lat + 20 && !got) begin
      @(negedge clk);
      k++;
      bus.START = (k == pulse_at);
      if (k == pulse_at) bus.NUM_PAT = 16'd5;
      if (bus.DONE) got = 1'b1;
    end
    bus.START = 1'b0;
    check($sformatf("latency_n%0d", n), got ? k : 0, lat);
  endtask

  initial begin
    bus.START   = 1'b0;
    bus.NUM_PAT = 16'd0;
    bus.ABORT   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ssel", {31'b0, bus.SSEL}, 32'd0);
    check("rst_sdin", {31'b0, bus.SDIN}, 32'd0);
    check("rst_busy", {31'b0, bus.BUSY}, 32'd0);
    check("rst_done", {31'b0, bus.DONE}, 32'd0);
    check("rst_sig", {16'b0, bus.SIG}, 32'd0);

    run(0, 0);
    run(1, 0);
    run(3, 0);
    run(3, 0);
    run(3, 20);
    check("sig_hold", {16'b0, bus.SIG}, {16'b0, model_sig(3)});

    // Abort on cycle 5 of the second load.
    start_run(3);
    repeat (13) @(posedge clk);
    #1;
    check("abort_pre_ssel", {31'b0, bus.SSEL}, 32'd1);
    bus.ABORT = 1'b1;
    @(posedge clk);
    #1 bus.ABORT = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, bus.BUSY}, 32'd0);
    check("abort_ssel", {31'b0, bus.SSEL}, 32'd0);
    check("abort_done", {31'b0, bus.DONE}, 32'd0);
    check("abort_sig", {16'b0, bus.SIG}, {16'b0, model_sig(3)});
    repeat (30) @(negedge clk);
    check("abort_sig_later", {16'b0, bus.SIG}, {16'b0, model_sig(3)});

    // Reset in the middle of the unload.
    start_run(1);
    repeat (11) @(posedge clk);
    #1;
    check("unload_pre_rst", {29'b0, bus.BUSY, bus.SSEL, bus.SDIN}, 32'b110);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ssel", {31'b0, bus.SSEL}, 32'd0);
    check("midrst_sdin", {31'b0, bus.SDIN}, 32'd0);
    check("midrst_busy", {31'b0, bus.BUSY}, 32'd0);
    check("midrst_done", {31'b0, bus.DONE}, 32'd0);
    check("midrst_sig", {16'b0, bus.SIG}, 32'd0);

    run(2, 0);
    repeat (3) @(negedge clk);
    check("leftover_exp", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
